// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM/digit encodings and sizing helpers for the radix-4 Booth multiplier
package booth_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} digit_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
  function automatic int iter_of(input int n);
    return n / 2 + 1;
  endfunction
  function automatic digit_e booth_digit(input logic [2:0] w);
    return (w == 3'b001 || w == 3'b010) ? P1 :
           (w == 3'b011)                 ? P2 :
           (w == 3'b100)                 ? M2 :
           (w == 3'b101 || w == 3'b110) ? M1 : ZERO;
  endfunction
endpackage

// File: rtl/booth_r4_recoder.sv
// booth_r4_recoder: turns a 3-bit Booth window and the extended multiplicand into a partial product
//   window_i  Qx[2:0] window (Q[1], Q[0], Q[-1])
//   mx_i      multiplicand extended to N+2 bits
//   pp_o      partial product sign-extended to N+4 bits
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   window_i,
  input  logic [N+1:0] mx_i,
  output logic [N+3:0] pp_o
);
  digit_e       digit;
  logic [N+3:0] m1;
  logic [N+3:0] m2;
  always_comb begin
    digit = booth_digit(window_i);
    m1    = {{2{mx_i[N+1]}}, mx_i};
    m2    = {m1[N+2:0], 1'b0};
    pp_o  = digit == P1 ? m1 :
            digit == P2 ? m2 :
            digit == M1 ? -m1 :
            digit == M2 ? -m2 : '0;
  end
endmodule

// File: rtl/booth_radix4_mult.sv
// booth_radix4_mult: sequential radix-4 Booth multiplier with signed/unsigned mode and start/busy/done handshake
//   clk_100MHz, rst_n (async, active-low)
//   start, signed_mode, data_inM, data_inQ: request and operands, taken when not busy
//   busy: high while iterating; done: one-cycle pulse as ans updates; ans: 2N-bit product
module booth_radix4_mult
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk_100MHz,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   data_inM,
  input  logic [N-1:0]   data_inQ,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] ans
);
  localparam int ITER = iter_of(N);
  localparam int CW   = clog2(N / 2 + 2);
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N+3:0]   a_q, a_d, pp, sum;
  logic [N+2:0]   qx_q, qx_d;
  logic [N+1:0]   mx_q, mx_d, m_ext, q_ext;
  logic [2*N-1:0] ans_q, ans_d;
  logic           done_q, done_d, accept;
  booth_r4_recoder #(.N(N)) u_recoder (
    .window_i(qx_q[2:0]),
    .mx_i    (mx_q),
    .pp_o    (pp)
  );
  // The product is published one edge after the last iteration, so a start taken in DONE
  // overlaps that publishing edge and back-to-back results come every ITER+1 cycles.
  always_comb begin
    m_ext   = {{2{signed_mode & data_inM[N-1]}}, data_inM};
    q_ext   = {{2{signed_mode & data_inQ[N-1]}}, data_inQ};
    accept  = start && state_q != RUN;
    sum     = a_q + pp;
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    qx_d    = qx_q;
    mx_d    = mx_q;
    ans_d   = ans_q;
    done_d  = 1'b0;
    if (state_q == RUN) begin
      a_d     = {{2{sum[N+3]}}, sum[N+3:2]};
      qx_d    = {sum[1:0], qx_q[N+2:2]};
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == CW'(1) ? DONE : RUN;
    end
    if (state_q == DONE) begin
      ans_d   = {a_q[N-3:0], qx_q[N+2:1]};
      done_d  = 1'b1;
      state_d = IDLE;
    end
    if (accept) begin
      a_d     = '0;
      qx_d    = {q_ext, 1'b0};
      mx_d    = m_ext;
      cnt_d   = CW'(ITER);
      state_d = RUN;
    end
  end
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      qx_q    <= '0;
      mx_q    <= '0;
      ans_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      qx_q    <= qx_d;
      mx_q    <= mx_d;
      ans_q   <= ans_d;
      done_q  <= done_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = done_q;
  assign ans  = ans_q;
endmodule

// File: tb/tb_booth_radix4_mult.sv
// tb_booth_radix4_mult: scoreboard bench for N=8 and N=32 instances against an arithmetic reference
module tb_booth_radix4_mult;
  typedef struct {
    logic [63:0] p;
    int          due;
  } exp_t;
  localparam int L8  = 6;
  localparam int L32 = 18;
  logic        clk;
  logic        rst_n8, rst_n32;
  logic        s8, sm8, s32, sm32;
  logic [7:0]  m8, q8v;
  logic [31:0] m32, q32v;
  logic        busy8, done8, busy32, done32;
  logic [15:0] ans8;
  logic [63:0] ans32;
  exp_t        sb8[$], sb32[$];
  exp_t        pe, e8, e32;
  int          cyc = 0;
  int          last8 = -100, last32 = -100;
  int          compared = 0, mismatched = 0;
  logic        pd8 = 1'b0, pd32 = 1'b0;
  booth_radix4_mult #(.N(8)) dut8 (
    .clk_100MHz(clk), .rst_n(rst_n8), .start(s8), .signed_mode(sm8),
    .data_inM(m8), .data_inQ(q8v), .busy(busy8), .done(done8), .ans(ans8)
  );
  booth_radix4_mult #(.N(32)) dut32 (
    .clk_100MHz(clk), .rst_n(rst_n32), .start(s32), .signed_mode(sm32),
    .data_inM(m32), .data_inQ(q32v), .busy(busy32), .done(done32), .ans(ans32)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [63:0] ref_prod(input logic [31:0] m, input logic [31:0] q,
                                           input logic sm, input int n);
    logic signed [31:0]  ms, qs;
    logic signed [127:0] a, b, p;
    logic [63:0]         mask;
    ms = $signed(m << (32 - n)) >>> (32 - n);
    qs = $signed(q << (32 - n)) >>> (32 - n);
    if (sm) begin
      a = ms;
      b = qs;
    end else begin
      a = {96'b0, m};
      b = {96'b0, q};
    end
    p    = a * b;
    mask = (64'h1 << (2 * n)) - 64'h1;
    return p[63:0] & mask;
  endfunction
  function automatic logic [31:0] pick();
    int unsigned r;
    r = $urandom_range(0, 7);
    return r == 0 ? 32'h0 : r == 1 ? 32'hFFFFFFFF : r == 2 ? 32'h80000000 :
           r == 3 ? 32'h7FFFFFFF : 32'($urandom);
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic fail(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: no matching expectation (t=%0t)", nm, $time);
  endtask
  // reference acceptance model: a start is taken when L cycles have passed since the last one
  always @(posedge clk) begin
    cyc++;
    if (!rst_n8) last8 = -100;
    else if (s8 && cyc >= last8 + L8) begin
      last8  = cyc;
      pe.p   = ref_prod({24'b0, m8}, {24'b0, q8v}, sm8, 8);
      pe.due = cyc + L8;
      sb8.push_back(pe);
    end
    if (!rst_n32) last32 = -100;
    else if (s32 && cyc >= last32 + L32) begin
      last32 = cyc;
      pe.p   = ref_prod(m32, q32v, sm32, 32);
      pe.due = cyc + L32;
      sb32.push_back(pe);
    end
  end
  always @(negedge clk) begin
    if (!rst_n8) begin
      chk("rst8_busy", {63'b0, busy8}, 64'd0);
      chk("rst8_done", {63'b0, done8}, 64'd0);
      chk("rst8_ans", {48'b0, ans8}, 64'd0);
      sb8.delete();
      pd8 = 1'b0;
    end else begin
      chk("busy8", {63'b0, busy8}, {63'b0, (cyc - last8) <= L8 - 2});
      if (done8) begin
        chk("pulse8", {63'b0, pd8}, 64'd0);
        if (sb8.size() == 0) fail("spurious_done8");
        else begin
          e8 = sb8.pop_front();
          chk("ans8", {48'b0, ans8}, e8.p);
          chk("latency8", 64'(cyc), 64'(e8.due));
        end
      end else if (sb8.size() != 0 && cyc >= sb8[0].due) begin
        void'(sb8.pop_front());
        fail("timeout8");
      end
      pd8 = done8;
    end
    if (!rst_n32) begin
      chk("rst32_busy", {63'b0, busy32}, 64'd0);
      chk("rst32_done", {63'b0, done32}, 64'd0);
      chk("rst32_ans", ans32, 64'd0);
      sb32.delete();
      pd32 = 1'b0;
    end else begin
      chk("busy32", {63'b0, busy32}, {63'b0, (cyc - last32) <= L32 - 2});
      if (done32) begin
        chk("pulse32", {63'b0, pd32}, 64'd0);
        if (sb32.size() == 0) fail("spurious_done32");
        else begin
          e32 = sb32.pop_front();
          chk("ans32", ans32, e32.p);
          chk("latency32", 64'(cyc), 64'(e32.due));
        end
      end else if (sb32.size() != 0 && cyc >= sb32[0].due) begin
        void'(sb32.pop_front());
        fail("timeout32");
      end
      pd32 = done32;
    end
  end
  task automatic op8(input logic [7:0] m, input logic [7:0] q, input logic sm);
    @(posedge clk);
    #1 s8 = 1'b1; m8 = m; q8v = q; sm8 = sm;
    @(posedge clk);
    #1 s8 = 1'b0; m8 = 8'($urandom); q8v = 8'($urandom); sm8 = ~sm;
    repeat (L8 + 2) @(posedge clk);
  endtask
  task automatic op32(input logic [31:0] m, input logic [31:0] q, input logic sm);
    @(posedge clk);
    #1 s32 = 1'b1; m32 = m; q32v = q; sm32 = sm;
    @(posedge clk);
    #1 s32 = 1'b0; m32 = $urandom; q32v = $urandom; sm32 = ~sm;
    repeat (L32 + 2) @(posedge clk);
  endtask
  initial begin
    s8 = 1'b0; sm8 = 1'b0; m8 = '0; q8v = '0;
    s32 = 1'b0; sm32 = 1'b0; m32 = '0; q32v = '0;
    rst_n8 = 1'b1; rst_n32 = 1'b1;
    #1 rst_n8 = 1'b0; rst_n32 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n8 = 1'b1; rst_n32 = 1'b1;
    op8(8'h1F, 8'h27, 1'b0);
    op8(8'h80, 8'h80, 1'b1);
    op8(8'h80, 8'h80, 1'b0);
    op8(8'hFF, 8'h01, 1'b1);
    op8(8'hFF, 8'hFF, 1'b0);
    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    op32(32'h80000000, 32'h80000000, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 s8 = 1'b1; m8 = 8'(pick() >> 24); q8v = 8'($urandom); sm8 = 1'($urandom);
    end
    #0 s8 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1 s32 = 1'b1; m32 = pick(); q32v = pick(); sm32 = 1'($urandom);
    end
    #0 s32 = 1'b0;
    repeat (L32 + 2) @(posedge clk);
    @(posedge clk);
    #1 s8 = 1'b1; m8 = 8'h5A; q8v = 8'hC3; sm8 = 1'b1;
    @(posedge clk);
    #1 s8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n8 = 1'b1;
    op8(8'h9D, 8'h6B, 1'b1);
    op8(8'h9D, 8'h6B, 1'b0);
    fork
      for (int i = 0; i < 40000; i++) begin
        @(posedge clk);
        #1 s8 = $urandom_range(0, 3) != 0; m8 = 8'(pick() >> 24); q8v = 8'(pick() >> 24);
        sm8 = 1'($urandom);
      end
      for (int i = 0; i < 40000; i++) begin
        @(posedge clk);
        #1 s32 = $urandom_range(0, 3) != 0; m32 = pick(); q32v = pick(); sm32 = 1'($urandom);
      end
    join
    s8 = 1'b0;
    s32 = 1'b0;
    for (int i = 0; i < 100 && (sb8.size() != 0 || sb32.size() != 0); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
